// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
//   Architecture-wide constants for the single-cycle RV32 datapath.
//   The decoder, control unit, ALU-source mux and the register file all use
//   these constants so that their widths stay consistent.
// ---------------------------------------------------------------------------
package rv_pkg;
    localparam int XLEN       = 32;   // data path width
    localparam int REG_COUNT  = 32;   // architectural registers
    localparam int REG_ADDR_W = 5;    // log2(REG_COUNT)

    // x0 is hardwired to zero.
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/reg_read_port.sv
// ---------------------------------------------------------------------------
// reg_read_port
//   One combinational read port of the register file: indexes the array,
//   forces x0 and the reset cycle to zero, and optionally forwards the
//   write port value when it targets the register being read (write-first).
// Ports
//   i_reset  in   reset is asserted; the output is forced to 0
//   i_regs   in   flattened storage array (entry 0 is unused)
//   i_we     in   write enable of the write port
//   i_waddr  in   write destination
//   i_wdata  in   write data
//   i_raddr  in   read index
//   o_rdata  out  read value
// ---------------------------------------------------------------------------
module reg_read_port import rv_pkg::*; #(
    parameter int DATA_WIDTH = XLEN,
    parameter int NUM_REGS   = REG_COUNT,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int BYPASS     = 1
) (
    input  logic                                 i_reset,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  i_regs,
    input  logic                                 i_we,
    input  logic [ADDR_WIDTH-1:0]                i_waddr,
    input  logic [DATA_WIDTH-1:0]                i_wdata,
    input  logic [ADDR_WIDTH-1:0]                i_raddr,
    output logic [DATA_WIDTH-1:0]                o_rdata
);
    logic w_hit;

    // A hit on x0 cannot forward: the x0 test below takes precedence, so
    // comparing the addresses alone is enough here.
    assign w_hit = (BYPASS != 0) && i_we && (i_waddr == i_raddr);

    always_comb begin
        o_rdata = '0;
        if (!i_reset && (i_raddr != ADDR_WIDTH'(ZERO_REG))) begin
            if (w_hit) o_rdata = i_wdata;
            else       o_rdata = i_regs[i_raddr];
        end
    end
endmodule

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   Architectural register file: NUM_REGS x DATA_WIDTH, two read ports with
//   optional same-cycle write forwarding, one write port, and a debug read
//   port that shows only committed state. x0 always reads as zero.
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high clear; outputs read 0 while high
//   we        in   write enable (RegWrite)
//   waddr     in   destination register rd
//   wdata     in   write-back value
//   raddr1    in   rs1 index      -> rdata1 (ALU operand A)
//   raddr2    in   rs2 index      -> rdata2 (ALU-source mux in1)
//   dbg_addr  in   debug index    -> dbg_data (never forwarded)
// ---------------------------------------------------------------------------
module reg_file import rv_pkg::*; #(
    parameter int DATA_WIDTH = XLEN,
    parameter int NUM_REGS   = REG_COUNT,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata2,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);
    localparam int NPORTS = 3;   // rs1, rs2, debug

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;
    logic [NPORTS-1:0][ADDR_WIDTH-1:0]   w_raddr;
    logic [NPORTS-1:0][DATA_WIDTH-1:0]   w_rdata;

    // Reset wins over a write in the same cycle; entry 0 is never written.
    always_ff @(posedge clk) begin
        if (reset)
            r_regs <= '0;
        else if (we && (waddr != ADDR_WIDTH'(ZERO_REG)))
            r_regs[waddr] <= wdata;
    end

    assign w_raddr = {dbg_addr, raddr2, raddr1};

    // Port 2 is the debug port: forwarding is tied off so it shows only
    // what has actually been committed.
    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        reg_read_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_REGS   (NUM_REGS),
            .ADDR_WIDTH (ADDR_WIDTH),
            .BYPASS     ((p == NPORTS - 1) ? 0 : BYPASS)
        ) u_port (
            .i_reset (reset),
            .i_regs  (r_regs),
            .i_we    (we),
            .i_waddr (waddr),
            .i_wdata (wdata),
            .i_raddr (w_raddr[p]),
            .o_rdata (w_rdata[p])
        );
    end

    assign rdata1   = w_rdata[0];
    assign rdata2   = w_rdata[1];
    assign dbg_data = w_rdata[2];
endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;
    logic        clk = 1'b0;
    logic        reset, we;
    logic [4:0]  waddr, raddr1, raddr2, dbg_addr;
    logic [31:0] wdata;
    logic [31:0] rd1_b, rd2_b, dbg_b;   // BYPASS=1 build
    logic [31:0] rd1_n, rd2_n, dbg_n;   // BYPASS=0 build

    int total = 0;
    int bad   = 0;

    // Reference model: committed register contents.
    logic [31:0] m [32];

    always #5 clk = ~clk;

    reg_file #(.BYPASS(1)) dut_b (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rd1_b), .raddr2(raddr2), .rdata2(rd2_b),
        .dbg_addr(dbg_addr), .dbg_data(dbg_b)
    );

    reg_file #(.BYPASS(0)) dut_n (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rd1_n), .raddr2(raddr2), .rdata2(rd2_n),
        .dbg_addr(dbg_addr), .dbg_data(dbg_n)
    );

    // Expected combinational read value from the behavioural rules.
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (reset)                          return 32'h0;
        if (a == 5'd0)                      return 32'h0;
        if (byp && we && waddr == a)        return wdata;
        return m[a];
    endfunction

    // Advance one clock edge and update the model with what was presented.
    task automatic step();
        logic        rs, w;
        logic [4:0]  wa;
        logic [31:0] wd;
        rs = reset; w = we; wa = waddr; wd = wdata;
        @(posedge clk);
        if (rs)                     for (int i = 0; i < 32; i++) m[i] = 32'h0;
        else if (w && wa != 5'd0)   m[wa] = wd;
        #1;
    endtask

    task automatic idle();
        we = 1'b0; waddr = 5'd0; wdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle();
        raddr1 = 5'd1; raddr2 = 5'd2; dbg_addr = 5'd3;
        step();
        step();
        #1;
        total++;
        if (rd1_b !== 32'h0 || rd2_b !== 32'h0 || dbg_b !== 32'h0) begin
            bad++;
            $display("FAIL reset_hold: rd1=%h rd2=%h dbg=%h expected 0", rd1_b, rd2_b, dbg_b);
        end
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            total++;
            if (dbg_b !== 32'h0 || dbg_n !== 32'h0) begin
                bad++;
                $display("FAIL reset_dbg[%0d]: got %h/%h expected 00000000", i, dbg_b, dbg_n);
            end
        end
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = 5'd5; wdata = 32'hAABBCCDD;
        step();
        idle(); raddr2 = 5'd5;
        #1;
        total++;
        if (rd2_b !== 32'hAABBCCDD || rd2_n !== 32'hAABBCCDD) begin
            bad++;
            $display("FAIL write_read_x5: got %h/%h expected aabbccdd", rd2_b, rd2_n);
        end
    endtask

    task automatic test_x0();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0;
        #1;
        total++;
        if (rd1_b !== 32'h0) begin
            bad++;
            $display("FAIL x0_no_bypass: got %h expected 00000000", rd1_b);
        end
        step();
        idle(); raddr1 = 5'd0; dbg_addr = 5'd0;
        #1;
        total++;
        if (rd1_b !== 32'h0 || dbg_b !== 32'h0 || rd1_n !== 32'h0) begin
            bad++;
            $display("FAIL x0_write: rd1=%h dbg=%h expected 00000000", rd1_b, dbg_b);
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; waddr = 5'd7; wdata = 32'h11223344;
        step();
        we = 1'b1; waddr = 5'd7; wdata = 32'h55667788;
        raddr1 = 5'd7; raddr2 = 5'd7; dbg_addr = 5'd7;
        #1;
        total++;
        if (rd1_b !== 32'h55667788 || rd2_b !== 32'h55667788) begin
            bad++;
            $display("FAIL bypass_both: rd1=%h rd2=%h expected 55667788", rd1_b, rd2_b);
        end
        total++;
        if (dbg_b !== 32'h11223344) begin
            bad++;
            $display("FAIL bypass_dbg_old: got %h expected 11223344", dbg_b);
        end
        total++;
        if (rd1_n !== 32'h11223344 || rd2_n !== 32'h11223344) begin
            bad++;
            $display("FAIL nobypass_old: rd1=%h rd2=%h expected 11223344", rd1_n, rd2_n);
        end
        step();
        idle();
        #1;
        total++;
        if (dbg_b !== 32'h55667788 || rd1_n !== 32'h55667788) begin
            bad++;
            $display("FAIL bypass_after_edge: dbg=%h rd1_n=%h expected 55667788", dbg_b, rd1_n);
        end
    endtask

    task automatic test_reset_vs_write();
        we = 1'b1; waddr = 5'd3; wdata = 32'h00000010;
        step();
        reset = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'h00000020;
        raddr1 = 5'd3; raddr2 = 5'd3; dbg_addr = 5'd3;
        #1;
        total++;
        if (rd1_b !== 32'h0 || rd2_b !== 32'h0 || dbg_b !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: rd1=%h rd2=%h dbg=%h expected 0", rd1_b, rd2_b, dbg_b);
        end
        step();
        reset = 1'b0; idle();
        #1;
        total++;
        if (dbg_b !== 32'h0 || rd1_b !== 32'h0 || rd1_n !== 32'h0) begin
            bad++;
            $display("FAIL reset_beats_write: x3=%h expected 00000000", dbg_b);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset    = ($urandom_range(0, 49) == 0);
            we       = $urandom_range(0, 2) != 0;
            waddr    = 5'($urandom_range(0, 31));
            wdata    = $urandom;
            raddr1   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            dbg_addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            #1;
            total++;
            if (rd1_b !== exp_rd(raddr1, 1'b1) || rd2_b !== exp_rd(raddr2, 1'b1)) begin
                bad++;
                $display("FAIL rand_bypass c=%0d: rd1=%h rd2=%h expected %h %h",
                         c, rd1_b, rd2_b, exp_rd(raddr1, 1'b1), exp_rd(raddr2, 1'b1));
            end
            total++;
            if (rd1_n !== exp_rd(raddr1, 1'b0) || rd2_n !== exp_rd(raddr2, 1'b0)) begin
                bad++;
                $display("FAIL rand_nobypass c=%0d: rd1=%h rd2=%h expected %h %h",
                         c, rd1_n, rd2_n, exp_rd(raddr1, 1'b0), exp_rd(raddr2, 1'b0));
            end
            total++;
            if (dbg_b !== exp_rd(dbg_addr, 1'b0) || dbg_n !== exp_rd(dbg_addr, 1'b0)) begin
                bad++;
                $display("FAIL rand_dbg c=%0d: got %h/%h expected %h",
                         c, dbg_b, dbg_n, exp_rd(dbg_addr, 1'b0));
            end
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0; dbg_addr = '0;
        #1;
        test_reset();
        test_write_read();
        test_x0();
        test_bypass();
        test_reset_vs_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
